// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the matrix keypad scanner.
package keypad_pkg;

  // Kind of result produced by one full scan of the keypad matrix.
  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  // Lock-side codes for the non-digit keys.
  localparam int unsigned KEY_STAR   = 13;
  localparam int unsigned KEY_HASH   = 14;
  localparam int unsigned KEY_LETTER = 15;

  // Phone-style 4x4 map, nibble n holds the code for idx n = row*4 + col.
  localparam logic [63:0] PHONE_MAP_TBL = {
    4'(KEY_LETTER), 4'(KEY_HASH), 4'd0, 4'(KEY_STAR),   // row3: *,0,#,D
    4'(KEY_LETTER), 4'd9,         4'd8, 4'd7,           // row2: 7,8,9,C
    4'(KEY_LETTER), 4'd6,         4'd5, 4'd4,           // row1: 4,5,6,B
    4'(KEY_LETTER), 4'd3,         4'd2, 4'd1            // row0: 1,2,3,A
  };

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Phone-style code for a 4x4 key index.
  function automatic logic [3:0] phone_map(input logic [3:0] idx);
    return PHONE_MAP_TBL[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Column-dwell prescaler: one-cycle tick on the last cycle of every dwell.
module keypad_scan_tick
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Next count, wrapping at the terminal value.
  always_comb begin
    cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter and registered tick, which is high exactly while cnt_q == TERM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == TERM);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with full-scan debounce and one-shot press events.
// Optional macro KEYPAD_PHONE_MAP_EN selects the phone-style 4x4 key code map
// instead of the linear row*N_COLS+col code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned N_ROWS         = 4,
  parameter int unsigned N_COLS         = 4,
  parameter int unsigned CODE_W         = 4,
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row,
  output logic [N_COLS-1:0] col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              scan_tick
);

  localparam int unsigned IDX_W = clog2(N_ROWS * N_COLS);
  localparam int unsigned CI_W  = clog2(N_COLS);
  localparam logic [3:0]  DEB   = 4'(DEBOUNCE_SCANS);

  if (CODE_W < IDX_W) begin : g_code_w_check
    $error("keypad_scanner: CODE_W too narrow for N_ROWS*N_COLS keys");
  end

`ifdef KEYPAD_PHONE_MAP_EN
  if (N_ROWS != 4 || N_COLS != 4 || CODE_W < 4) begin : g_phone_map_check
    $error("keypad_scanner: phone map requires a 4x4 matrix and CODE_W >= 4");
  end
`endif

  logic              tick;
  logic [N_COLS-1:0] col_q;
  logic [CI_W-1:0]   col_idx_q;
  logic [1:0]        hit_cnt_q, hit_cnt_d;
  logic [IDX_W-1:0]  first_idx_q, first_idx_d;
  scan_kind_e        cand_q, res_kind;
  logic [IDX_W-1:0]  cand_idx_q;
  logic [3:0]        stable_cnt_q, stable_cnt_d;
  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q;
  logic              key_held_q;

  logic [1:0]        row_hits;
  logic [IDX_W-1:0]  row_first;
  logic [2:0]        hit_sum;
  logic              eos;
  logic              same;
  logic              fire;
  logic [CODE_W-1:0] key_map;

  keypad_scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Fold the current column's rows into the scan accumulators and judge the scan result.
  always_comb begin
    row_hits  = 2'd0;
    row_first = '0;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if (row[r]) row_first = IDX_W'(r * N_COLS) + IDX_W'(col_idx_q);
    end
    for (int r = 0; r < N_ROWS; r++) begin
      if (row[r] && row_hits != 2'd2) row_hits = row_hits + 2'd1;
    end

    hit_sum     = {1'b0, hit_cnt_q} + {1'b0, row_hits};
    hit_cnt_d   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    first_idx_d = (hit_cnt_q == 2'd0) ? row_first : first_idx_q;
    eos         = tick && (col_idx_q == CI_W'(N_COLS - 1));

    case (hit_cnt_d)
      2'd0:    res_kind = SCAN_NONE;
      2'd1:    res_kind = SCAN_SINGLE;
      default: res_kind = SCAN_MULTI;
    endcase

    same = (res_kind == cand_q) &&
           ((res_kind != SCAN_SINGLE) || (first_idx_d == cand_idx_q));
    if (same) stable_cnt_d = (stable_cnt_q == DEB) ? DEB : stable_cnt_q + 4'd1;
    else      stable_cnt_d = 4'd1;

    // Fire only on the scan where the count reaches DEB, not while it sits saturated.
    fire = eos && (stable_cnt_d == DEB) && !(same && (stable_cnt_q == DEB));
  end

`ifdef KEYPAD_PHONE_MAP_EN
  assign key_map = CODE_W'(phone_map(4'(first_idx_d)));
`else
  assign key_map = CODE_W'(first_idx_d);
`endif

  // Column rotation and per-scan accumulation, advanced once per dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= N_COLS'(1);
      col_idx_q   <= '0;
      hit_cnt_q   <= 2'd0;
      first_idx_q <= '0;
    end else if (tick) begin
      col_q     <= {col_q[N_COLS-2:0], col_q[N_COLS-1]};
      col_idx_q <= (col_idx_q == CI_W'(N_COLS - 1)) ? '0 : col_idx_q + CI_W'(1);
      if (eos) begin
        hit_cnt_q   <= 2'd0;
        first_idx_q <= '0;
      end else begin
        hit_cnt_q   <= hit_cnt_d;
        first_idx_q <= first_idx_d;
      end
    end
  end

  // Debounce FSM: candidate result, stability count and press/release events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q       <= SCAN_NONE;
      cand_idx_q   <= '0;
      stable_cnt_q <= 4'd0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (eos) begin
        if (!same) begin
          cand_q     <= res_kind;
          cand_idx_q <= first_idx_d;
        end
        stable_cnt_q <= stable_cnt_d;
        if (fire) begin
          case (res_kind)
            SCAN_SINGLE: begin
              // A new key while another is still held is roll-over: no event.
              if (!key_held_q) begin
                key_code_q  <= key_map;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end
            end
            SCAN_NONE: key_held_q <= 1'b0;
            default:   ;
          endcase
        end
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign scan_tick = tick;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a 4x4 switch-matrix model drives the rows,
// expected press events are queued at stimulus time and a monitor checks them.
module tb_keypad_scanner;

  localparam int unsigned NR  = 4;
  localparam int unsigned NC  = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned SD  = 4;
  localparam int unsigned DEB = 3;

`ifdef KEYPAD_PHONE_MAP_EN
  localparam int C_R1C2 = 6;
  localparam int C_R3C0 = 13;
  localparam int C_R2C1 = 8;
  localparam int C_R0C1 = 2;
  localparam int C_R0C2 = 3;
`else
  localparam int C_R1C2 = 6;
  localparam int C_R3C0 = 12;
  localparam int C_R2C1 = 9;
  localparam int C_R0C1 = 1;
  localparam int C_R0C2 = 2;
`endif

  typedef struct {
    int code;
    int scan;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] row_s;
  logic [NC-1:0] col_s;
  logic [CW-1:0] key_code_s;
  logic          key_valid_s;
  logic          key_held_s;
  logic          scan_tick_s;

  logic [15:0]   pressed;
  ev_t           exp_q[$];
  int            scan_no;
  int            checks;
  int            failures;

  always #5 clk = ~clk;

  keypad_scanner #(
    .N_ROWS        (NR),
    .N_COLS        (NC),
    .CODE_W        (CW),
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row_s),
    .col      (col_s),
    .key_code (key_code_s),
    .key_valid(key_valid_s),
    .key_held (key_held_s),
    .scan_tick(scan_tick_s)
  );

  // Switch matrix: a row reads 1 when a pressed key sits in a driven column.
  always_comb begin
    row_s = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (pressed[r*NC + c] && col_s[c]) row_s[r] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Queue a press event expected DEB scans after the scan that starts now.
  task automatic expect_key(input int code);
    ev_t e;
    e.code = code;
    e.scan = scan_no + int'(DEB);
    exp_q.push_back(e);
  endtask

  // Return just after the next end-of-scan edge, bounded.
  task automatic wait_eos();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < int'(4 * NC * SD + 8); i++) begin
      @(negedge clk);
      if (scan_tick_s && col_s[NC-1]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("eos_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [15:0] mask, input int n);
    pressed = mask;
    for (int i = 0; i < n; i++) wait_eos();
  endtask

  task automatic monitor_loop();
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        scan_no = 0;
      end else begin
        if (scan_tick_s && col_s[NC-1]) scan_no++;
        if (key_valid_s) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_key_valid: got code %0d at scan %0d, expected no pulse",
                     key_code_s, scan_no);
          end else begin
            e = exp_q.pop_front();
            chk("key_code", int'(key_code_s), e.code);
            chk("accept_scan", scan_no, e.scan);
          end
        end
      end
    end
  endtask

  initial begin
    int ticks;
    int last;
    checks   = 0;
    failures = 0;
    scan_no  = 0;
    pressed  = '0;
    rst      = 1'b1;
    fork
      monitor_loop();
    join_none

    // Reset values.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_col", int'(col_s), 1);
    chk("rst_key_valid", int'(key_valid_s), 0);
    chk("rst_key_held", int'(key_held_s), 0);
    chk("rst_key_code", int'(key_code_s), 0);
    chk("rst_scan_tick", int'(scan_tick_s), 0);

    // Reset in cycle 7, during the second column's dwell.
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("col_before_midreset", int'(col_s), 2);
    rst = 1'b1;
    #1;
    chk("midreset_col", int'(col_s), 1);
    chk("midreset_key_valid", int'(key_valid_s), 0);
    chk("midreset_key_held", int'(key_held_s), 0);
    chk("midreset_key_code", int'(key_code_s), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First tick in cycle SD after release, then column walk over two scans.
    ticks = 0;
    last  = 0;
    for (int cyc = 1; cyc <= 64 && ticks < int'(2 * NC); cyc++) begin
      @(negedge clk);
      if (scan_tick_s) begin
        if (ticks == 0) chk("first_tick_cycle", cyc, int'(SD));
        else            chk("tick_spacing", cyc - last, int'(SD));
        chk("col_walk", int'(col_s), 1 << (ticks % int'(NC)));
        chk("col_onehot", int'($onehot(col_s)), 1);
        last = cyc;
        ticks++;
      end
    end
    chk("tick_count", ticks, int'(2 * NC));
    wait_eos();

    // Clean press r1c2, held 5 scans, then release.
    expect_key(C_R1C2);
    hold(16'h0040, 5);
    chk("a_held_pressed", int'(key_held_s), 1);
    hold(16'h0000, 2);
    chk("a_held_2_empty", int'(key_held_s), 1);
    hold(16'h0000, 1);
    chk("a_held_released", int'(key_held_s), 0);

    // Bouncing press r3c0: present, absent, then present 3 scans.
    hold(16'h1000, 1);
    hold(16'h0000, 1);
    chk("b_no_early_hold", int'(key_held_s), 0);
    expect_key(C_R3C0);
    hold(16'h1000, 3);
    chk("b_held", int'(key_held_s), 1);
    hold(16'h0000, 3);
    chk("b_released", int'(key_held_s), 0);

    // Two keys together give no event; dropping one leaves r2c1 alone.
    hold(16'h0201, 6);
    chk("c_multi_not_held", int'(key_held_s), 0);
    expect_key(C_R2C1);
    hold(16'h0200, 3);
    chk("c_single_held", int'(key_held_s), 1);
    hold(16'h0000, 3);
    chk("c_released", int'(key_held_s), 0);

    // Roll-over r0c1 -> r0c2 with no empty scan: only the first key reports.
    expect_key(C_R0C1);
    hold(16'h0002, 3);
    chk("d_first_held", int'(key_held_s), 1);
    hold(16'h0004, 4);
    chk("d_rollover_held", int'(key_held_s), 1);
    chk("d_rollover_code", int'(key_code_s), C_R0C1);
    hold(16'h0000, 3);
    chk("d_released", int'(key_held_s), 0);
    expect_key(C_R0C2);
    hold(16'h0004, 3);
    chk("d_second_held", int'(key_held_s), 1);

    // Reset while a key is held clears the event outputs at once.
    @(posedge clk);
    #2;
    rst     = 1'b1;
    pressed = '0;
    #1;
    chk("end_rst_col", int'(col_s), 1);
    chk("end_rst_key_held", int'(key_held_s), 0);
    chk("end_rst_key_code", int'(key_code_s), 0);
    chk("end_rst_scan_tick", int'(scan_tick_s), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4 * NC * SD) @(posedge clk);
    #1;
    chk("pending_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
